tensor_core_mma_engine: RTL and testbench

//  Parametrised sequential matrix-multiply-accumulate engine: R = A*B (+ C), all DIM x DIM signed

---
 rtl/tensor_core_mma_engine.sv | 142 ++++++++++++++
 tb/tb_tensor_core_mma_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_mma_engine.sv
// Sequential DIM x DIM signed matrix multiply-accumulate engine: one result element per cycle,
// reduced by saturation or wrap, published atomically to result_out on entry to DONE.

module tensor_core_mma_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] p
);
    assign p = a * b;
endmodule

module tensor_core_mma_engine #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic                           start_in,
    input  logic                           accumulate_in,
    input  logic                           saturate_in,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]  matrix_a_in,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]  matrix_b_in,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]  matrix_c_in,
    output logic                           ready_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic [DIM*DIM*DATA_WIDTH-1:0]  result_out,
    output logic                           overflow_out
);
    localparam int MW = DIM*DIM*DATA_WIDTH;
    localparam int PW = 2*DATA_WIDTH;
    localparam int AW = PW + $clog2(DIM) + 1;
    localparam int IW = $clog2(DIM);

    localparam logic signed [AW-1:0] SMAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                            state_q, state_d;
    logic [MW-1:0]                     a_q, b_q, c_q, work_q, work_d, result_q;
    logic                              acc_mode_q, sat_mode_q, work_ovf_q, ovf_q;
    logic [IW-1:0]                     row_q, col_q;
    logic                              last_elem;
    logic [DIM-1:0][DATA_WIDTH-1:0]    a_row, b_col;
    logic [DIM-1:0][PW-1:0]            prods;
    logic signed [AW-1:0]              acc_sum;
    logic                              elem_ovf;
    logic [DATA_WIDTH-1:0]             elem_red;
    int                                elem_idx;

    assign last_elem = (row_q == IW'(DIM-1)) && (col_q == IW'(DIM-1));

    // Row i of A and column j of B feed the DIM parallel multiplier lanes.
    always_comb begin
        a_row    = '0;
        b_col    = '0;
        elem_idx = ((DIM-1-int'(row_q))*DIM + (DIM-1-int'(col_q)))*DATA_WIDTH;
        for (int n = 0; n < DIM; n++) begin
            a_row[n] = a_q[((DIM-1-int'(row_q))*DIM + (DIM-1-n))*DATA_WIDTH +: DATA_WIDTH];
            b_col[n] = b_q[((DIM-1-n)*DIM + (DIM-1-int'(col_q)))*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar n = 0; n < DIM; n++) begin : g_lane
        tensor_core_mma_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .a(a_row[n]),
            .b(b_col[n]),
            .p(prods[n])
        );
    end

    always_comb begin
        acc_sum = '0;
        for (int n = 0; n < DIM; n++)
            acc_sum = acc_sum + AW'($signed(prods[n]));
        if (acc_mode_q)
            acc_sum = acc_sum + AW'($signed(c_q[elem_idx +: DATA_WIDTH]));
        elem_ovf = (acc_sum > SMAX) || (acc_sum < SMIN);
        elem_red = acc_sum[DATA_WIDTH-1:0];
        if (sat_mode_q && acc_sum > SMAX) elem_red = SMAX[DATA_WIDTH-1:0];
        if (sat_mode_q && acc_sum < SMIN) elem_red = SMIN[DATA_WIDTH-1:0];
        work_d = work_q;
        work_d[elem_idx +: DATA_WIDTH] = elem_red;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = COMPUTE;
            COMPUTE: if (last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            a_q <= '0; b_q <= '0; c_q <= '0; work_q <= '0; result_q <= '0;
            acc_mode_q <= 1'b0; sat_mode_q <= 1'b0; work_ovf_q <= 1'b0; ovf_q <= 1'b0;
            row_q <= '0; col_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_in) begin
                    a_q <= matrix_a_in; b_q <= matrix_b_in; c_q <= matrix_c_in;
                    acc_mode_q <= accumulate_in; sat_mode_q <= saturate_in;
                    work_ovf_q <= 1'b0;
                    row_q <= '0; col_q <= '0;
                end
                COMPUTE: begin
                    work_q     <= work_d;
                    work_ovf_q <= work_ovf_q | elem_ovf;
                    if (col_q == IW'(DIM-1)) begin
                        col_q <= '0;
                        row_q <= row_q + IW'(1);
                    end else begin
                        col_q <= col_q + IW'(1);
                    end
                    // The last element lands in the published copy on the same edge.
                    if (last_elem) begin
                        result_q <= work_d;
                        ovf_q    <= work_ovf_q | elem_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_out    = (state_q == IDLE);
    assign busy_out     = (state_q == COMPUTE);
    assign done_out     = (state_q == DONE);
    assign result_out   = result_q;
    assign overflow_out = ovf_q;
endmodule

// File: tb/tb_tensor_core_mma_engine.sv
// Scoreboard bench for tensor_core_mma_engine: directed cases plus randomized ops checked
// against an integer-arithmetic matrix model.

module tb_tensor_core_mma_engine;
    localparam int DIM = 4;
    localparam int DW  = 8;
    localparam int MW  = DIM*DIM*DW;

    typedef int mat_t [DIM][DIM];
    typedef struct {
        logic [MW-1:0] res;
        logic          ovf;
        int            done_cyc;
    } exp_t;

    exp_t exp_q[$];

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          start_in = 1'b0;
    logic          accumulate_in = 1'b0;
    logic          saturate_in = 1'b0;
    logic [MW-1:0] matrix_a_in = '0, matrix_b_in = '0, matrix_c_in = '0;
    logic          ready_out, busy_out, done_out, overflow_out;
    logic [MW-1:0] result_out;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    tensor_core_mma_engine #(.DIM(DIM), .DATA_WIDTH(DW)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
        .accumulate_in(accumulate_in), .saturate_in(saturate_in),
        .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in), .matrix_c_in(matrix_c_in),
        .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out),
        .result_out(result_out), .overflow_out(overflow_out)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [MW-1:0] pack(input mat_t m);
        logic [MW-1:0] p;
        logic [31:0]   t;
        p = '0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                t = m[i][j];
                p[((DIM-1-i)*DIM + (DIM-1-j))*DW +: DW] = t[DW-1:0];
            end
        return p;
    endfunction

    // Reference: exact integer sum per element, then clamp or keep low bits.
    function automatic exp_t model(input mat_t a, input mat_t b, input mat_t c,
                                   input bit acc, input bit sat, input int dc);
        exp_t        e;
        int          s, r, lo, hi;
        logic [31:0] t;
        lo = -(1 << (DW-1));
        hi = (1 << (DW-1)) - 1;
        e.res = '0; e.ovf = 1'b0; e.done_cyc = dc;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int n = 0; n < DIM; n++) s += a[i][n] * b[n][j];
                if (acc) s += c[i][j];
                if (s > hi || s < lo) e.ovf = 1'b1;
                r = s;
                if (sat && s > hi) r = hi;
                if (sat && s < lo) r = lo;
                t = r;
                e.res[((DIM-1-i)*DIM + (DIM-1-j))*DW +: DW] = t[DW-1:0];
            end
        return e;
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) m[i][j] = v;
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) m[i][j] = (i == j) ? 1 : 0;
        return m;
    endfunction

    function automatic mat_t rmat(input int mode);
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                case (mode)
                    0:       m[i][j] = int'($urandom_range(0, 255)) - 128;
                    1:       m[i][j] = int'($urandom_range(0, 8)) - 4;
                    default: m[i][j] = $urandom_range(0, 1) ? 127 : -128;
                endcase
        return m;
    endfunction

    // Monitor: reset values after a reset edge, scoreboard pop on done, otherwise result held.
    initial begin
        logic [MW-1:0] held_res;
        logic          held_ovf;
        logic          rst_s;
        exp_t          e;
        held_res = '0;
        held_ovf = 1'b0;
        forever begin
            @(posedge clock_in);
            rst_s = reset_in;
            #1;
            if (rst_s) begin
                check("reset_result", result_out, '0);
                check("reset_ovf", MW'(overflow_out), '0);
                check("reset_ready", MW'(ready_out), MW'(1));
                check("reset_busy", MW'(busy_out), '0);
                check("reset_done", MW'(done_out), '0);
                held_res = '0;
                held_ovf = 1'b0;
            end else if (done_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", MW'(done_out), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result_out, e.res);
                    check("overflow", MW'(overflow_out), MW'(e.ovf));
                    check("done_cycle", MW'(cyc), MW'(e.done_cyc));
                    held_res = e.res;
                    held_ovf = e.ovf;
                end
            end else begin
                check("hold_result", result_out, held_res);
                check("hold_ovf", MW'(overflow_out), MW'(held_ovf));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        @(negedge clock_in);
        while (!ready_out && t < 200) begin
            @(negedge clock_in);
            t++;
        end
        ok = ready_out;
        if (!ok) check("ready_timeout", MW'(ready_out), MW'(1));
    endtask

    task automatic drive(input mat_t a, input mat_t b, input mat_t c, input bit acc, input bit sat);
        matrix_a_in = pack(a); matrix_b_in = pack(b); matrix_c_in = pack(c);
        accumulate_in = acc; saturate_in = sat;
        start_in = 1'b1;
    endtask

    task automatic scramble();
        matrix_a_in = {4{$urandom()}}; matrix_b_in = {4{$urandom()}}; matrix_c_in = {4{$urandom()}};
        accumulate_in = 1'($urandom_range(0, 1)); saturate_in = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input mat_t a, input mat_t b, input mat_t c, input bit acc, input bit sat);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            drive(a, b, c, acc, sat);
            exp_q.push_back(model(a, b, c, acc, sat, cyc + DIM*DIM + 1));
            @(negedge clock_in);
            check("busy_after_accept", MW'({busy_out, ready_out}), MW'(2'b10));
            start_in = 1'b0;
            scramble();
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clock_in);
            t++;
        end
        check("drain_queue_empty", MW'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    initial begin
        mat_t bseq, z;
        mat_t op2a, op2b;
        bit   ok;
        int   c0;
        z = fill(0);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) bseq[i][j] = i*4 + j;

        repeat (3) @(negedge clock_in);
        reset_in = 1'b0;

        issue(ident(), bseq, z, 1'b0, 1'b0);
        issue(ident(), fill(2), fill(3), 1'b1, 1'b0);
        issue(ident(), fill(2), fill(3), 1'b0, 1'b1);
        issue(fill(127), fill(127), z, 1'b0, 1'b1);
        issue(fill(127), fill(127), z, 1'b0, 1'b0);
        issue(fill(-128), fill(127), z, 1'b0, 1'b1);
        issue(fill(-128), fill(127), z, 1'b0, 1'b0);
        issue(fill(-128), fill(-128), fill(-128), 1'b1, 1'b1);
        drain();

        // Reset during COMPUTE: aborts with no done pulse.
        wait_ready(ok);
        if (ok) begin
            c0 = cyc;
            drive(fill(127), fill(127), z, 1'b0, 1'b1);
            @(negedge clock_in);
            start_in = 1'b0;
            while (cyc < c0 + 5) @(negedge clock_in);
            reset_in = 1'b1;
            @(negedge clock_in);
            reset_in = 1'b0;
            check("ready_after_abort", MW'({ready_out, busy_out}), MW'(2'b10));
            repeat (20) @(negedge clock_in);
        end

        // Start held high: second op accepted on the first ready cycle, extras ignored.
        wait_ready(ok);
        if (ok) begin
            c0 = cyc;
            drive(ident(), bseq, z, 1'b0, 1'b0);
            exp_q.push_back(model(ident(), bseq, z, 1'b0, 1'b0, c0 + 17));
            @(negedge clock_in);
            op2a = rmat(1); op2b = rmat(1);
            drive(op2a, op2b, fill(5), 1'b1, 1'b1);
            exp_q.push_back(model(op2a, op2b, fill(5), 1'b1, 1'b1, c0 + 35));
            while (cyc < c0 + 19) @(negedge clock_in);
            check("second_accept_busy", MW'(busy_out), MW'(1));
            start_in = 1'b0;
            scramble();
            drain();
        end

        for (int k = 0; k < 24; k++) begin
            int ma, mb;
            ma = int'($urandom_range(0, 2));
            mb = int'($urandom_range(0, 2));
            issue(rmat(ma), rmat(mb), rmat(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        repeat (5) @(negedge clock_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
